// File: rtl/regfile_pkg.sv
// picomips_pkg: shared constants and types for the picoMIPS datapath.
//   DATALENGTH / ADDRWIDTH : default word and register-address widths
//   R_ZERO / R_SWITCH / R_LED : special register indices
//   data_t : signed data word shared between register file and ALU
package picomips_pkg;

  localparam int DATALENGTH = 8;
  localparam int ADDRWIDTH  = 3;

  localparam int R_ZERO   = 0;
  localparam int R_SWITCH = 1;
  localparam int R_LED    = (2 ** ADDRWIDTH) - 1;

  typedef logic signed [DATALENGTH-1:0] data_t;

endpackage

// File: rtl/regfile_if.sv
// regfile_if: register-file access bus between control/ALU and the register file.
//   we, waddr, wdata : write port
//   raddr1, raddr2   : read port indices (rs, rt)
//   rdata1, rdata2   : signed read data feeding ALU operands a and b
// Modports: master (datapath side), slave (register file side).
interface regfile_if
  import picomips_pkg::*;
#(
  parameter int datalength = DATALENGTH,
  parameter int addrwidth  = ADDRWIDTH
);

  logic                         we;
  logic [addrwidth-1:0]         waddr;
  logic [datalength-1:0]        wdata;
  logic [addrwidth-1:0]         raddr1;
  logic [addrwidth-1:0]         raddr2;
  logic signed [datalength-1:0] rdata1;
  logic signed [datalength-1:0] rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/regfile_sync2.sv
// sync2: two-flop synchroniser for asynchronous inputs.
//   clk    : sampling clock
//   nReset : synchronous active-low reset, clears both stages
//   d      : asynchronous input word
//   q      : synchronised output, valid one edge after the first sampling edge
module sync2 #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta_r;
  logic [width-1:0] sync_r;

  // Two-stage capture; the first stage may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      meta_r <= {width{1'b0}};
      sync_r <= {width{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/regfile.sv
// regfile: picoMIPS register file with memory-mapped I/O.
//   clk, nReset           : clock, synchronous active-low reset
//   bus (regfile_if.slave): write port and two combinational read ports
//   sw_in                 : asynchronous switch word, read through R1
//   sw_ready, in_ack      : asynchronous button and its consume pulse
//   in_ready              : sticky "new input available" flag
//   leds                  : contents of the top register (R_LED)
// R0 reads zero, R1 reads the synchronised switches, writes to both are
// dropped. Optional macro REGFILE_BYPASS_EN forwards write data to a read
// port addressing the register being written in the same cycle; without it
// reads return the pre-write value.
module regfile
  import picomips_pkg::*;
#(
  parameter int datalength = DATALENGTH,
  parameter int addrwidth  = ADDRWIDTH
) (
  input  logic                  clk,
  input  logic                  nReset,
  regfile_if.slave              bus,
  input  logic [datalength-1:0] sw_in,
  input  logic                  sw_ready,
  input  logic                  in_ack,
  output logic                  in_ready,
  output logic [datalength-1:0] leds
);

  localparam int nregs = 2 ** addrwidth;
  localparam logic [addrwidth-1:0] r_zero   = addrwidth'(R_ZERO);
  localparam logic [addrwidth-1:0] r_switch = addrwidth'(R_SWITCH);
  localparam logic [addrwidth-1:0] r_led    = addrwidth'(nregs - 1);

  logic [datalength-1:0] regs_r [nregs];
  logic [datalength-1:0] sw_sync_s;
  logic [datalength-1:0] rd1_s;
  logic [datalength-1:0] rd2_s;
  logic                  rdy_sync_s;
  logic                  hist_r;
  logic                  in_ready_r;
  logic                  rise_s;
  logic                  wr_ok_s;

  // Value seen at a read index before any same-cycle forwarding.
  function automatic logic [datalength-1:0] port_value(
    input logic [addrwidth-1:0]  addr,
    input logic [datalength-1:0] stored,
    input logic [datalength-1:0] sw
  );
    logic [datalength-1:0] v;
    case (addr)
      r_zero:   v = {datalength{1'b0}};
      r_switch: v = sw;
      default:  v = stored;
    endcase
    return v;
  endfunction

  sync2 #(.width(datalength)) u_sw_sync (
    .clk    (clk),
    .nReset (nReset),
    .d      (sw_in),
    .q      (sw_sync_s)
  );

  sync2 #(.width(1)) u_rdy_sync (
    .clk    (clk),
    .nReset (nReset),
    .d      (sw_ready),
    .q      (rdy_sync_s)
  );

  // R0 and R1 are not writable; everything else, including R_LED, is stored.
  assign wr_ok_s = bus.we && (bus.waddr != r_zero) && (bus.waddr != r_switch);
  assign rise_s  = rdy_sync_s && !hist_r;

`ifdef REGFILE_BYPASS_EN
  assign rd1_s = (wr_ok_s && (bus.raddr1 == bus.waddr)) ? bus.wdata
               : port_value(bus.raddr1, regs_r[bus.raddr1], sw_sync_s);
  assign rd2_s = (wr_ok_s && (bus.raddr2 == bus.waddr)) ? bus.wdata
               : port_value(bus.raddr2, regs_r[bus.raddr2], sw_sync_s);
`else
  assign rd1_s = port_value(bus.raddr1, regs_r[bus.raddr1], sw_sync_s);
  assign rd2_s = port_value(bus.raddr2, regs_r[bus.raddr2], sw_sync_s);
`endif

  assign bus.rdata1 = rd1_s;
  assign bus.rdata2 = rd2_s;

  // Register storage write port.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      for (int i = 0; i < nregs; i++) begin
        regs_r[i] <= {datalength{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[bus.waddr] <= bus.wdata;
    end
  end

  // Button edge history and sticky ready flag; a new press beats a same-cycle ack.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      hist_r     <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      hist_r <= rdy_sync_s;
      if (rise_s) begin
        in_ready_r <= 1'b1;
      end else if (in_ack) begin
        in_ready_r <= 1'b0;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign leds     = regs_r[r_led];

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile. Directed scenarios followed by
// randomized traffic, all compared with a behavioural model kept here.
module tb_regfile;
  import picomips_pkg::*;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] sw_in;
  logic       sw_ready;
  logic       in_ack;
  logic       in_ready;
  logic [7:0] leds;

  regfile_if bus ();

  regfile dut (
    .clk      (clk),
    .nReset   (nReset),
    .bus      (bus),
    .sw_in    (sw_in),
    .sw_ready (sw_ready),
    .in_ack   (in_ack),
    .in_ready (in_ready),
    .leds     (leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: register contents, switch/button samples taken at recent edges
  // (index 0 = most recent edge), and the ready flag.
  logic [7:0] m_regs [8];
  logic [7:0] m_sw   [2];
  logic       m_btn  [3];
  logic       m_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected read data: switches appear two sampling edges late.
  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 8'd0;
    if (a == 3'd1) return m_sw[1];
`ifdef REGFILE_BYPASS_EN
    if (bus.we && (a == bus.waddr)) return bus.wdata;
`endif
    return m_regs[a];
  endfunction

  // Model state change at a rising edge, using the inputs present at that edge.
  task automatic model_edge();
    logic rise;
    if (!nReset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
      m_sw[0] = 8'd0; m_sw[1] = 8'd0;
      m_btn[0] = 1'b0; m_btn[1] = 1'b0; m_btn[2] = 1'b0;
      m_ready = 1'b0;
    end else begin
      // Button press seen two edges ago, not seen three edges ago.
      rise = m_btn[1] && !m_btn[2];
      if (rise) m_ready = 1'b1;
      else if (in_ack) m_ready = 1'b0;
      m_btn[2] = m_btn[1]; m_btn[1] = m_btn[0]; m_btn[0] = sw_ready;
      m_sw[1] = m_sw[0]; m_sw[0] = sw_in;
      if (bus.we && (bus.waddr > 3'd1)) m_regs[bus.waddr] = bus.wdata;
    end
  endtask

  // One clock: check combinational reads before the edge, registered outputs after.
  task automatic cycle();
    #1;
    check_eq("rdata1", {24'h0, bus.rdata1}, {24'h0, m_read(bus.raddr1)});
    check_eq("rdata2", {24'h0, bus.rdata2}, {24'h0, m_read(bus.raddr2)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("leds", {24'h0, leds}, {24'h0, m_regs[R_LED]});
    check_eq("in_ready", {31'h0, in_ready}, {31'h0, m_ready});
  endtask

  initial begin
    nReset = 1'b0; sw_in = 8'd0; sw_ready = 1'b0; in_ack = 1'b0;
    bus.we = 1'b0; bus.waddr = 3'd0; bus.wdata = 8'd0;
    bus.raddr1 = 3'd3; bus.raddr2 = 3'd7;

    // Reset: two edges, DUT state undefined before the first one.
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    #1;
    check_eq("rst_rdata1", {24'h0, bus.rdata1}, 32'h0);
    check_eq("rst_rdata2", {24'h0, bus.rdata2}, 32'h0);
    check_eq("rst_leds", {24'h0, leds}, 32'h0);
    check_eq("rst_in_ready", {31'h0, in_ready}, 32'h0);
    nReset = 1'b1;

    // R0 is hardwired zero.
    bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 8'h55; bus.raddr1 = 3'd0;
    cycle();
    bus.we = 1'b0; #1;
    check_eq("r0_zero", {24'h0, bus.rdata1}, 32'h0);

    // Plain writes then reads.
    bus.we = 1'b1; bus.waddr = 3'd3; bus.wdata = 8'd50; cycle();
    bus.waddr = 3'd4; bus.wdata = 8'b01000000; cycle();
    bus.we = 1'b0; bus.raddr1 = 3'd3; bus.raddr2 = 3'd4; #1;
    check_eq("r3", {24'h0, bus.rdata1}, 32'd50);
    check_eq("r4", {24'h0, bus.rdata2}, 32'd64);
    check_eq("alu_add", 32'(int'(bus.rdata1) + int'(bus.rdata2)), 32'd114);

    // Same-cycle read of the register being written.
    bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 8'hCE; bus.raddr1 = 3'd5; #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("war_r5", {24'h0, bus.rdata1}, 32'hCE);
`else
    check_eq("war_r5", {24'h0, bus.rdata1}, 32'h0);
`endif
    cycle();
    bus.we = 1'b0; #1;
    check_eq("r5_signed", 32'(int'(bus.rdata1)), 32'hFFFFFFCE);

    // Switch path latency and read-only R1.
    sw_in = 8'd24; bus.raddr1 = 3'd1;
    cycle();
    check_eq("sw_edgeN", {24'h0, bus.rdata1}, 32'h0);
    cycle();
    check_eq("sw_edgeN1", {24'h0, bus.rdata1}, 32'd24);
    bus.we = 1'b1; bus.waddr = 3'd1; bus.wdata = 8'hFF; cycle();
    bus.we = 1'b0; #1;
    check_eq("r1_ro", {24'h0, bus.rdata1}, 32'd24);

    // Handshake: press, acknowledge, hold, release, press again.
    sw_ready = 1'b1;
    cycle(); check_eq("hs_edgeN", {31'h0, in_ready}, 32'h0);
    cycle(); check_eq("hs_edgeN1", {31'h0, in_ready}, 32'h0);
    cycle(); check_eq("hs_set", {31'h0, in_ready}, 32'h1);
    cycle(); cycle();
    in_ack = 1'b1; cycle(); in_ack = 1'b0;
    check_eq("hs_ack", {31'h0, in_ready}, 32'h0);
    repeat (3) cycle();
    check_eq("hs_held", {31'h0, in_ready}, 32'h0);
    sw_ready = 1'b0; repeat (3) cycle();
    sw_ready = 1'b1; repeat (3) cycle();
    check_eq("hs_press2", {31'h0, in_ready}, 32'h1);
    // Clear, release, press with an ack landing on the setting edge.
    sw_ready = 1'b0; in_ack = 1'b1; cycle(); in_ack = 1'b0;
    check_eq("hs_clear2", {31'h0, in_ready}, 32'h0);
    cycle(); cycle();
    sw_ready = 1'b1; cycle(); cycle();
    in_ack = 1'b1; cycle(); in_ack = 1'b0;
    check_eq("hs_set_wins", {31'h0, in_ready}, 32'h1);

    // LED register, then reset in the middle of activity.
    bus.we = 1'b1; bus.waddr = 3'd7; bus.wdata = 8'h81; bus.raddr1 = 3'd7; cycle();
    check_eq("leds_81", {24'h0, leds}, 32'h81);
    bus.we = 1'b0; #1;
    check_eq("r7_signed", 32'(int'(bus.rdata1)), 32'hFFFFFF81);
    nReset = 1'b0; bus.we = 1'b1; bus.waddr = 3'd6; bus.wdata = 8'h3C; cycle();
    check_eq("mid_rst_leds", {24'h0, leds}, 32'h0);
    check_eq("mid_rst_ready", {31'h0, in_ready}, 32'h0);
    nReset = 1'b1; bus.we = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      nReset     = ($urandom_range(0, 59) != 0);
      bus.we     = 1'($urandom_range(0, 1));
      bus.waddr  = 3'($urandom_range(0, 7));
      bus.wdata  = 8'($urandom);
      bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr : 3'($urandom_range(0, 7));
      bus.raddr2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) sw_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) sw_ready = ~sw_ready;
      in_ack = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Register file that directly feeds the ALU operand inputs `a` and `b` in the picoMIPS affine-transform datapath, and accepts the ALU `result` as write-back data.
- Contains the processor's I/O mapping:
  - register 1 reads the synchronised switch word;
  - the top register drives the LEDs;
  - a synchronised handshake button raises an "input ready" flag for the control unit to poll and acknowledge.

Parameters:
- datalength, 8: data word width; matches the ALU operand width.
- addrwidth, 3: register address width; 2**addrwidth registers.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nReset  input  1  synchronous, active-low reset.
- we  input  1  write enable for the write port.
- waddr  input  addrwidth  write register index.
- wdata  input  datalength  write data (ALU result or immediate).
- raddr1  input  addrwidth  read port 1 index (rs); drives ALU `a`.
- raddr2  input  addrwidth  read port 2 index (rt); drives ALU `b`.
- rdata1  output  datalength  read port 1 data, signed.
- rdata2  output  datalength  read port 2 data, signed.
- sw_in  input  datalength  asynchronous switch word.
- sw_ready  input  1  asynchronous handshake button, active high.
- in_ack  input  1  one-cycle pulse from the control unit consuming the input.
- in_ready  output  1  sticky flag: new input available.
- leds  output  datalength  contents of the LED register.

Behaviour:
- Reset:
  - Synchronous, active-low: when nReset is low at a rising edge, all registers, both synchroniser stages, the edge-detect history flop, in_ready and leds clear to 0.
  - Reset overrides we and in_ack in the same cycle.
  - Reset mid-operation discards a pending write and any pending ready flag.
- Reads:
  - Combinational, zero latency.
  - R0 reads constant 0.
  - R1 reads the synchroniser output sw_sync.
  - Any other index reads the stored register.
- Writes: at a rising edge when we=1, the register at waddr is updated with wdata, except:
  - waddr=0: ignored (R0 hardwired zero).
  - waddr=1: ignored (R1 is a read-only input).
  - waddr=2**addrwidth-1 (R_LED): stored, and leds follows the stored value from the same edge.
- Switch path: two-flop synchroniser.
  - A sw_in change sampled at edge N appears on sw_sync, and on reads of R1, after edge N+1.
- Handshake:
  - sw_ready passes through the same two-flop synchroniser, then a history flop.
  - A rising edge of the synchronised signal (sync=1, hist=0) sets in_ready at the next edge, i.e. after edge N+2 for an input sampled at edge N.
  - in_ready stays set until in_ack=1 at an edge.
  - A held button does not re-set in_ready after it has been acknowledged; a new press requires a release first.
  - If a new rising edge and in_ack occur in the same cycle, set wins and in_ready stays 1.
  - in_ack while in_ready=0 has no effect.
- Same-address read and write in one cycle: the read returns the old value (write-after-read), unless BYPASS_EN is defined.
- Address 2**addrwidth-1 aliases R_LED for both reads and writes; no other wrap-around exists.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when we=1 and raddrX==waddr, with waddr neither 0 nor 1, rdataX returns wdata combinationally in the same cycle.
- Undefined: rdataX returns the pre-write stored value.

Decomposition:
- Package picomips_pkg holds:
  - the datalength and addrwidth defaults;
  - constants R_ZERO=0, R_SWITCH=1, R_LED=2**addrwidth-1;
  - a typedef for the signed data word shared with the ALU.
- Sub-module sync2: a parameterised two-flop synchroniser with synchronous active-low reset, instantiated once for the switch word and once for sw_ready.

Test Plan:
- Reset and R0:
  - nReset=0 for 2 edges → rdata1, rdata2, leds, in_ready all 0.
  - Write we=1, waddr=0, wdata=8'h55 → reading R0 still returns 0.
- Write and read: write R3=50 and R4=8'b01000000.
  - Then raddr1=3, raddr2=4 → rdata1=50, rdata2=64.
  - With the ALU attached, func=1 gives result 114.
- Write-after-read: a same-cycle read of R5 while writing 8'hCE returns the old value 0; it reads -50 after the edge.
  - Under REGFILE_BYPASS_EN it returns -50 in the same cycle.
- Switch sync: sw_in=24 applied before edge N.
  - R1 reads old value at edge N and 24 after N+1.
  - A write of 8'hFF to R1 is ignored; R1 still reads 24.
- Handshake:
  - Pulse sw_ready high for 5 cycles → in_ready=1 after 2nd edge post-sample.
  - in_ack pulse clears it.
  - Holding sw_ready high keeps in_ready at 0.
  - A release then second press sets it again.
  - A new rising edge coincident with in_ack keeps in_ready at 1.
- LEDs: write R7=-127 → leds=8'h81 after the edge.
  - nReset low mid-sequence → leds=0 and in_ready=0.
